// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with store-data forwarding and retired-instruction counter
//
// Purpose:
//    Registers the EX-stage results and control fields into the MEM stage.
//    Per clock edge the priority is rst > flush_exmem > stall_exmem > load.
//    Store data (rD2) is forwarded from the register-file write-back port,
//    both when it is captured and while it is held under a stall. This lets a
//    stalled store pick up a value that WB writes while the store is stalled.
//
// Ports:
//    clk_cpu        in   1   pipeline clock, rising edge
//    rst            in   1   synchronous active-high reset
//    stall_exmem    in   1   hold current contents
//    flush_exmem    in   1   load a bubble
//    valid_ex       in   1   EX holds a real instruction
//    alu_c_ex       in  32   ALU result
//    rD2_ex         in  32   rs2 data (store data)
//    imm_ex         in  32   extended immediate
//    pc4_ex         in  32   PC+4
//    rs2_ex         in   5   rs2 index
//    wR_ex          in   5   destination register index
//    rf_we_ex       in   1   register-file write enable
//    dram_we_ex     in   1   data-memory write enable
//    wd_sel_ex      in   2   write-back source select
//    rf_we_wb       in   1   WB register-file write enable
//    wR_wb          in   5   WB destination index
//    wD_wb          in  32   WB write data
//    addr_mem, rD2_mem, imm_mem, pc4_mem       out 32   registered data fields
//    wR_mem (5), rf_we_mem, dram_we_mem, valid_mem (1), wd_sel_mem (2)  out
//    inst_cnt_mem   out  32   valid instructions accepted into MEM

module ex_mem_reg (
   input  logic        clk_cpu,
   input  logic        rst,
   input  logic        stall_exmem,
   input  logic        flush_exmem,
   input  logic        valid_ex,
   input  logic [31:0] alu_c_ex,
   input  logic [31:0] rD2_ex,
   input  logic [31:0] imm_ex,
   input  logic [31:0] pc4_ex,
   input  logic [4:0]  rs2_ex,
   input  logic [4:0]  wR_ex,
   input  logic        rf_we_ex,
   input  logic        dram_we_ex,
   input  logic [1:0]  wd_sel_ex,
   input  logic        rf_we_wb,
   input  logic [4:0]  wR_wb,
   input  logic [31:0] wD_wb,
   output logic [31:0] addr_mem,
   output logic [31:0] rD2_mem,
   output logic [31:0] imm_mem,
   output logic [31:0] pc4_mem,
   output logic [4:0]  wR_mem,
   output logic        rf_we_mem,
   output logic        dram_we_mem,
   output logic        valid_mem,
   output logic [1:0]  wd_sel_mem,
   output logic [31:0] inst_cnt_mem
);

   // Write-back source select codes
   localparam logic [1:0] WD_SEL_ALU  = 2'b00;
   localparam logic [1:0] WD_SEL_DRAM = 2'b01;
   localparam logic [1:0] WD_SEL_IMM  = 2'b10;
   localparam logic [1:0] WD_SEL_PC4  = 2'b11;

   // rs2 index of the held instruction, kept so held store data can be refreshed
   logic [4:0] rs2_mem;

   // x0 is never a forwarding source
   logic fwd_capture;
   logic fwd_held;

   assign fwd_capture = rf_we_wb && (wR_wb != 5'd0) && (wR_wb == rs2_ex);
   assign fwd_held    = rf_we_wb && (wR_wb != 5'd0) && (wR_wb == rs2_mem);

   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         addr_mem     <= 32'd0;
         rD2_mem      <= 32'd0;
         imm_mem      <= 32'd0;
         pc4_mem      <= 32'd0;
         wR_mem       <= 5'd0;
         rs2_mem      <= 5'd0;
         rf_we_mem    <= 1'b0;
         dram_we_mem  <= 1'b0;
         valid_mem    <= 1'b0;
         wd_sel_mem   <= WD_SEL_ALU;
         inst_cnt_mem <= 32'd0;
      end else if (flush_exmem || (!stall_exmem && !valid_ex)) begin
         // Bubble: flush (stall ignored) or a load of a non-instruction
         addr_mem     <= 32'd0;
         rD2_mem      <= 32'd0;
         imm_mem      <= 32'd0;
         pc4_mem      <= 32'd0;
         wR_mem       <= 5'd0;
         rs2_mem      <= 5'd0;
         rf_we_mem    <= 1'b0;
         dram_we_mem  <= 1'b0;
         valid_mem    <= 1'b0;
         wd_sel_mem   <= WD_SEL_ALU;
      end else if (stall_exmem) begin
         // Hold everything; only the store data may be refreshed from WB
         if (valid_mem && fwd_held) begin
            rD2_mem <= wD_wb;
         end
      end else begin
         addr_mem     <= alu_c_ex;
         rD2_mem      <= fwd_capture ? wD_wb : rD2_ex;
         imm_mem      <= imm_ex;
         pc4_mem      <= pc4_ex;
         wR_mem       <= wR_ex;
         rs2_mem      <= rs2_ex;
         rf_we_mem    <= rf_we_ex;
         dram_we_mem  <= dram_we_ex;
         valid_mem    <= 1'b1;
         wd_sel_mem   <= wd_sel_ex;
         inst_cnt_mem <= inst_cnt_mem + 32'd1;   // wraps naturally at 2^32
      end
   end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Clocking and reset SHALL be: one clock, clk_cpu; reset rst is synchronous and active-high.
REQ-002 clk_cpu  in  1  CPU pipeline clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 stall_exmem  in  1  hold current contents (hazard unit).
REQ-005 flush_exmem  in  1  replace contents with a bubble next edge.
REQ-006 valid_ex  in  1  EX holds a real instruction.
REQ-007 alu_c_ex  in  32  ALU result (address or value).
REQ-008 rD2_ex  in  32  rs2 register data (store data).
REQ-009 imm_ex  in  32  extended immediate.
REQ-010 pc4_ex  in  32  PC+4 of EX instruction.
REQ-011 rs2_ex  in  5  rs2 index.
REQ-012 wR_ex  in  5  destination register index.
REQ-013 rf_we_ex  in  1  register-file write enable.
REQ-014 dram_we_ex  in  1  data-memory write enable.
REQ-015 wd_sel_ex  in  2  write-back source select, codes alu/dram/imm/pc4 from the shared defines file.
REQ-016 rf_we_wb, wR_wb, wD_wb  in  1/5/32  write-back port of the register file.
REQ-017 addr_mem, rD2_mem, imm_mem, pc4_mem  out  32 each  registered copies to the MEM stage.
REQ-018 wR_mem  out  5; rf_we_mem, dram_we_mem, valid_mem  out  1; wd_sel_mem  out  2.
REQ-019 inst_cnt_mem  out  32  count of valid instructions accepted into MEM.

Function
REQ-020 Per-edge priority SHALL be: rst > flush_exmem > stall_exmem > load.
REQ-021 Load: all _mem registers SHALL take their _ex inputs on the edge; latency exactly one cycle.
REQ-022 A load with valid_ex=0 SHALL store a bubble, not the _ex control fields.
REQ-023 Bubble: rf_we_mem=0, dram_we_mem=0, valid_mem=0, wR_mem=0, wd_sel_mem=alu code, all 32-bit data fields 0.
REQ-024 Flush SHALL store a bubble regardless of stall_exmem.
REQ-025 Stall: all fields SHALL hold, except the store-data refresh rule REQ-027.
REQ-026 Capture forwarding: on load, if rf_we_wb=1, wR_wb!=0 and wR_wb==rs2_ex, rD2_mem SHALL take wD_wb instead of rD2_ex.
REQ-027 Held refresh: a registered rs2_mem index SHALL be kept; while stalled with valid_mem=1, if rf_we_wb=1, wR_wb!=0 and wR_wb==rs2_mem, rD2_mem SHALL update to wD_wb.
REQ-028 Register x0 SHALL never be a forwarding match.
REQ-029 inst_cnt_mem SHALL increment by 1 on each load edge with valid_ex=1 and no flush or stall.
REQ-030 inst_cnt_mem SHALL hold on stall, flush and bubble loads.
REQ-031 inst_cnt_mem SHALL wrap 0xFFFFFFFF -> 0.
REQ-032 No output SHALL depend combinationally on any input; all outputs come straight from flops.

Reset
REQ-033 On rst=1 at an edge, all outputs SHALL take bubble values (REQ-023) and inst_cnt_mem=0, regardless of stall/flush.
REQ-034 Reset asserted mid-stall SHALL discard held contents; first edge after rst deasserts performs a normal load.

Verification
REQ-035 Load: valid_ex=1, alu_c_ex=0x0000_1004, wR_ex=5, rf_we_ex=1, wd_sel=dram -> next edge: addr_mem=0x1004, wR_mem=5, rf_we_mem=1, valid_mem=1, inst_cnt_mem=1.
REQ-036 Stall then flush: contents loaded, stall_exmem=1 for 3 cycles with changing _ex inputs -> outputs unchanged; then stall=1 and flush=1 -> bubble, inst_cnt_mem unchanged.
REQ-037 Capture forward: rs2_ex=7, rD2_ex=0x11, rf_we_wb=1, wR_wb=7, wD_wb=0xAB -> rD2_mem=0xAB; repeat with wR_wb=0 and rs2_ex=0 -> rD2_mem=rD2_ex.
REQ-038 Held refresh: store held (rs2=9, rD2_mem=0x22) under stall, WB writes x9=0x5A -> rD2_mem=0x5A while still stalled.
REQ-039 Reset mid-operation: valid contents and inst_cnt_mem=0x10, rst=1 with stall=1 -> all outputs bubble, inst_cnt_mem=0.
REQ-040 Counter wrap: inst_cnt_mem preset to 0xFFFFFFFF via 0xFFFFFFFF valid loads or a forced state, one more valid load -> inst_cnt_mem=0.
